// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and helpers for the pipeline stall controller.
package pipeline_stall_controller_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MULDIV  = 2'd1,
      ST_MEMWAIT = 2'd2
   } stall_state_e;

   // Per-cycle control word for the PC and the four pipeline registers.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
   } stage_ctrl_t;

   localparam stage_ctrl_t CtrlFreeze  = stage_ctrl_t'(7'b00000_00);
   localparam stage_ctrl_t CtrlAdvance = stage_ctrl_t'(7'b11111_00);
   localparam stage_ctrl_t CtrlSquash  = stage_ctrl_t'(7'b11111_11);
   localparam stage_ctrl_t CtrlBubble  = stage_ctrl_t'(7'b00111_01);

   // Ceiling log2, never below one bit so counters stay legal.
   function automatic int unsigned clog2_min1(input int unsigned value);
      int unsigned bits;
      bits = 0;
      while ((64'd1 << bits) < 64'(value)) begin
         bits = bits + 1;
      end
      if (bits == 0) begin
         bits = 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and stage-register controls between the pipeline and its controller.
interface pipeline_stall_controller_if #(
   parameter int unsigned RegAddrBits = 5
) ();

   logic                   Tick;
   logic [RegAddrBits-1:0] id_rs;
   logic [RegAddrBits-1:0] id_rt;
   logic                   id_uses_rs;
   logic                   id_uses_rt;
   logic                   ex_mem_read;
   logic [RegAddrBits-1:0] ex_rd;
   logic                   ex_muldiv_start;
   logic                   ex_branch_taken;
   logic                   mem_ready;

   logic                   pc_en;
   logic                   ifid_en;
   logic                   idex_en;
   logic                   exmem_en;
   logic                   memwb_en;
   logic                   ifid_flush;
   logic                   idex_flush;
   logic                   muldiv_busy;
   logic                   mem_timeout;

   // Pipeline side: reports hazards, consumes enables.
   modport master (
      output Tick, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
             ex_muldiv_start, ex_branch_taken, mem_ready,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             muldiv_busy, mem_timeout
   );

   // Controller side.
   modport slave (
      input  Tick, id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
             ex_muldiv_start, ex_branch_taken, mem_ready,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
             muldiv_busy, mem_timeout
   );

endinterface

// File: rtl/pipeline_hazard_detect.sv
// Combinational load-use comparator: ID source vs. load destination in EX.
module pipeline_hazard_detect #(
   parameter int unsigned RegAddrBits = 5
) (
   input  logic [RegAddrBits-1:0] id_rs_i,
   input  logic [RegAddrBits-1:0] id_rt_i,
   input  logic                   id_uses_rs_i,
   input  logic                   id_uses_rt_i,
   input  logic                   ex_mem_read_i,
   input  logic [RegAddrBits-1:0] ex_rd_i,
   output logic                   hazard_c_o
);

   logic rs_match_c;
   logic rt_match_c;

   // r0 is hardwired zero, so a load targeting it never creates a dependency.
   always_comb begin
      rs_match_c = id_uses_rs_i & (id_rs_i == ex_rd_i);
      rt_match_c = id_uses_rt_i & (id_rt_i == ex_rd_i);
      hazard_c_o = ex_mem_read_i & (ex_rd_i != '0) & (rs_match_c | rt_match_c);
   end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the five-stage pipeline registers and PC.
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int unsigned MulDivLatency = 32,
   parameter int unsigned RegAddrBits   = 5,
   parameter int unsigned MemTimeout    = 1023
) (
   input  logic                        Clock,
   input  logic                        Reset,
   pipeline_stall_controller_if.slave  pipe_io
);

   localparam int unsigned MulCntBits  = 8;
   localparam int unsigned WaitCntBits = clog2_min1(MemTimeout + 1);
   localparam logic [MulCntBits-1:0]  MulCntInit = MulCntBits'(MulDivLatency - 2);
   localparam logic [WaitCntBits-1:0] WaitMax    = WaitCntBits'(MemTimeout);

   stall_state_e           state_q, state_d;
   logic [MulCntBits-1:0]  mul_cnt_q, mul_cnt_d;
   logic [WaitCntBits-1:0] wait_cnt_q, wait_cnt_d;
   logic                   mem_timeout_q, mem_timeout_d;

   logic        hazard_c;
   logic        advance_c;
   stage_ctrl_t ctrl_c;

   pipeline_hazard_detect #(
      .RegAddrBits (RegAddrBits)
   ) u_hazard (
      .id_rs_i       (pipe_io.id_rs),
      .id_rt_i       (pipe_io.id_rt),
      .id_uses_rs_i  (pipe_io.id_uses_rs),
      .id_uses_rt_i  (pipe_io.id_uses_rt),
      .ex_mem_read_i (pipe_io.ex_mem_read),
      .ex_rd_i       (pipe_io.ex_rd),
      .hazard_c_o    (hazard_c)
   );

   // Priority decode: memory wait, mul/div occupancy, branch squash, load-use bubble.
   always_comb begin
      state_d       = state_q;
      mul_cnt_d     = mul_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      ctrl_c        = CtrlFreeze;
      advance_c     = pipe_io.Tick & ~Reset;

      if (advance_c) begin
         if (!pipe_io.mem_ready) begin
            // Whole pipe waits; an interrupted mul/div keeps its count but will restart.
            state_d = ST_MEMWAIT;
            if (wait_cnt_q != WaitMax) begin
               wait_cnt_d = wait_cnt_q + WaitCntBits'(1);
            end
            if (wait_cnt_d == WaitMax) begin
               mem_timeout_d = 1'b1;
            end
         end else begin
            // The timeout counts consecutive wait cycles only.
            wait_cnt_d = '0;
            if (state_q == ST_MULDIV) begin
               if (mul_cnt_q != '0) begin
                  mul_cnt_d = mul_cnt_q - MulCntBits'(1);
               end else begin
                  ctrl_c  = CtrlAdvance;
                  state_d = ST_RUN;
               end
            end else if (pipe_io.ex_muldiv_start) begin
               mul_cnt_d = MulCntInit;
               state_d   = ST_MULDIV;
            end else if (pipe_io.ex_branch_taken) begin
               ctrl_c  = CtrlSquash;
               state_d = ST_RUN;
            end else if (hazard_c) begin
               ctrl_c  = CtrlBubble;
               state_d = ST_RUN;
            end else begin
               ctrl_c  = CtrlAdvance;
               state_d = ST_RUN;
            end
         end
      end
   end

   // State and counter registers; Tick=0 leaves the _d values equal to _q.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q       <= ST_RUN;
         mul_cnt_q     <= '0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         mul_cnt_q     <= mul_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   // Stage controls are Mealy so decisions land in the same cycle as the hazard.
   assign pipe_io.pc_en       = ctrl_c.pc_en;
   assign pipe_io.ifid_en     = ctrl_c.ifid_en;
   assign pipe_io.idex_en     = ctrl_c.idex_en;
   assign pipe_io.exmem_en    = ctrl_c.exmem_en;
   assign pipe_io.memwb_en    = ctrl_c.memwb_en;
   assign pipe_io.ifid_flush  = ctrl_c.ifid_flush;
   assign pipe_io.idex_flush  = ctrl_c.idex_flush;
   assign pipe_io.muldiv_busy = (state_q == ST_MULDIV);
   assign pipe_io.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed scoreboard bench for pipeline_stall_controller (MulDivLatency=4, MemTimeout=3).
module tb_pipeline_stall_controller;

   localparam int unsigned Lat  = 4;
   localparam int unsigned Ab   = 5;
   localparam int unsigned Tmo  = 3;

   // Expected vector: {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl, busy, timeout}
   localparam logic [8:0] E_RUN  = 9'b11111_00_0_0;
   localparam logic [8:0] E_FRZ  = 9'b00000_00_0_0;
   localparam logic [8:0] E_BUB  = 9'b00111_01_0_0;
   localparam logic [8:0] E_BR   = 9'b11111_11_0_0;
   localparam logic [8:0] E_BUSY = 9'b00000_00_1_0;
   localparam logic [8:0] E_EXIT = 9'b11111_00_1_0;
   localparam logic [8:0] E_TMO  = 9'b00000_00_0_1;

   typedef struct packed {
      logic          rst;
      logic          tick;
      logic [Ab-1:0] rs;
      logic [Ab-1:0] rt;
      logic          urs;
      logic          urt;
      logic          mrd;
      logic [Ab-1:0] rd;
      logic          mds;
      logic          bt;
      logic          rdy;
   } stim_t;

   typedef struct {
      string      name;
      logic [8:0] exp;
   } exp_t;

   logic  Clock = 1'b0;
   logic  Reset;
   stim_t st;
   exp_t  sb[$];
   exp_t  mon_e;
   logic [8:0] act;
   int    total = 0;
   int    bad   = 0;

   always #5 Clock = ~Clock;

   pipeline_stall_controller_if #(.RegAddrBits(Ab)) bus ();

   pipeline_stall_controller #(
      .MulDivLatency (Lat),
      .RegAddrBits   (Ab),
      .MemTimeout    (Tmo)
   ) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .pipe_io (bus)
   );

   task automatic idle();
      st      = '0;
      st.tick = 1'b1;
      st.rdy  = 1'b1;
   endtask

   task automatic apply();
      Reset               = st.rst;
      bus.Tick            = st.tick;
      bus.id_rs           = st.rs;
      bus.id_rt           = st.rt;
      bus.id_uses_rs      = st.urs;
      bus.id_uses_rt      = st.urt;
      bus.ex_mem_read     = st.mrd;
      bus.ex_rd           = st.rd;
      bus.ex_muldiv_start = st.mds;
      bus.ex_branch_taken = st.bt;
      bus.mem_ready       = st.rdy;
   endtask

   // Drive one cycle of staged inputs just after the edge and post its expectation.
   task automatic cyc(input string nm, input logic [8:0] exp);
      exp_t e;
      @(posedge Clock);
      #1;
      apply();
      e.name = nm;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   // Monitor: compares the combinational outputs mid-cycle against the queue head.
   initial begin
      forever begin
         @(negedge Clock);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.ifid_flush, bus.idex_flush, bus.muldiv_busy, bus.mem_timeout};
            total = total + 1;
            if (act !== mon_e.exp) begin
               bad = bad + 1;
               $display("FAIL %s: got %b want %b", mon_e.name, act, mon_e.exp);
            end
         end
      end
   end

   initial begin
      idle();
      st.rst = 1'b1;
      apply();
      cyc("reset", E_FRZ);

      idle(); cyc("normal", E_RUN);
      st.tick = 1'b0; st.bt = 1'b1; cyc("tick0_frozen", E_FRZ);

      idle(); st.mrd = 1'b1; st.rd = 5'd3; st.rs = 5'd3; st.urs = 1'b1;
      cyc("loaduse_rs", E_BUB);
      idle(); cyc("after_bubble", E_RUN);
      idle(); st.mrd = 1'b1; st.rd = 5'd0; st.rs = 5'd0; st.urs = 1'b1;
      cyc("loaduse_r0", E_RUN);
      idle(); st.mrd = 1'b1; st.rd = 5'd7; st.rt = 5'd7; st.urt = 1'b1; st.rs = 5'd7;
      cyc("loaduse_rt", E_BUB);
      idle(); st.mrd = 1'b1; st.rd = 5'd7; st.rt = 5'd7; st.rs = 5'd7;
      cyc("uses_flags_off", E_RUN);
      idle(); st.rd = 5'd7; st.rs = 5'd7; st.urs = 1'b1;
      cyc("not_a_load", E_RUN);
      idle(); st.bt = 1'b1; st.mrd = 1'b1; st.rd = 5'd3; st.rs = 5'd3; st.urs = 1'b1;
      cyc("branch_beats_hazard", E_BR);

      // Mul/div of latency 4: three frozen cycles then advance.
      idle(); st.mds = 1'b1; cyc("md_entry", E_FRZ);
      idle(); cyc("md_cnt2", E_BUSY);
      idle(); cyc("md_cnt1", E_BUSY);
      idle(); cyc("md_exit", E_EXIT);
      idle(); cyc("md_after", E_RUN);

      // Tick toggling inside MULDIV stretches the occupancy.
      idle(); st.mds = 1'b1; cyc("mdt_entry", E_FRZ);
      idle(); st.tick = 1'b0; st.rdy = 1'b0; cyc("mdt_t0a", E_BUSY);
      idle(); cyc("mdt_cnt2", E_BUSY);
      idle(); st.tick = 1'b0; cyc("mdt_t0b", E_BUSY);
      idle(); cyc("mdt_cnt1", E_BUSY);
      idle(); st.tick = 1'b0; cyc("mdt_t0c", E_BUSY);
      idle(); cyc("mdt_exit", E_EXIT);
      idle(); cyc("mdt_after", E_RUN);

      // Five memory wait cycles; the timeout flag appears on the fourth.
      idle(); st.rdy = 1'b0; cyc("mw1", E_FRZ);
      cyc("mw2", E_FRZ);
      cyc("mw3", E_FRZ);
      cyc("mw4_timeout", E_TMO);
      cyc("mw5", E_TMO);
      idle(); cyc("mw_resume", E_RUN | E_TMO);
      idle(); cyc("timeout_sticky", E_RUN | E_TMO);

      // Memory wait during MULDIV restarts the full latency.
      idle(); st.mds = 1'b1; cyc("mdw_entry", E_TMO);
      idle(); st.rdy = 1'b0; cyc("mdw_stall", E_BUSY | E_TMO);
      idle(); st.mds = 1'b1; cyc("mdw_restart", E_TMO);
      idle(); cyc("mdw_cnt2", E_BUSY | E_TMO);
      idle(); cyc("mdw_cnt1", E_BUSY | E_TMO);
      idle(); cyc("mdw_exit", E_EXIT | E_TMO);

      // Reset between edges while busy.
      idle(); st.mds = 1'b1; cyc("rst_md_entry", E_TMO);
      idle(); cyc("rst_md_busy", E_BUSY | E_TMO);
      idle(); st.rst = 1'b1; cyc("rst_mid_muldiv", E_FRZ);
      idle(); cyc("post_reset", E_RUN);
      idle(); cyc("post_reset2", E_RUN);

      repeat (4) @(posedge Clock);
      if (sb.size() != 0) begin
         total = total + 1;
         bad   = bad + 1;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central sequencer for the five-stage CPU pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. Every cycle it decides which stages advance, which hold and which are flushed to a bubble. It covers load-use hazards, taken branches resolved in EX, iterative multiply/divide occupancy, and data-memory wait states. Its outputs drive the ClockEnable inputs and the bubble/clear controls of the pipeline flip-flop registers.

## Interface
- MulDivLatency, 32: ticked cycles a mul/div instruction occupies EX; legal range 2..255.
- RegAddrBits, 5: register-number width.
- MemTimeout, 1023: maximum consecutive MEMWAIT cycles before the error flag is set.

- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Tick  in  1  global advance qualifier; when 0 the pipeline is frozen.
- id_rs, id_rt  in  RegAddrBits  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  valid flags for id_rs / id_rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  RegAddrBits  destination register of the instruction in EX.
- ex_muldiv_start  in  1  instruction in EX is a mul/div.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_ready  in  1  data memory completes the MEM-stage access this cycle; tied to 1 when there is no access.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage register enables.
- ifid_flush, idex_flush  out  1  load a bubble (all-zero) into the stage register on this edge.
- muldiv_busy  out  1  state is MULDIV.
- mem_timeout  out  1  sticky error flag.

## Operation
- FSM states: RUN, MULDIV, MEMWAIT. Outputs are combinational from state and inputs (Mealy).
- When Reset=1 or Tick=0:
  - all enables and flushes are 0.
  - On Tick=0, the state, counters and mem_timeout hold.
- Priority when Tick=1 (highest first), identical in every state:
  1. mem_ready=0: all enables 0, go to (or stay in) MEMWAIT, wait_cnt+1.
  2. MULDIV with mul_cnt≠0: all enables 0, mul_cnt−1.
  3. MULDIV with mul_cnt=0: all enables 1, no flush, go to RUN.
  4. RUN/MEMWAIT with ex_muldiv_start=1: all enables 0, mul_cnt←MulDivLatency−2, go to MULDIV.
  5. ex_branch_taken=1: all enables 1, ifid_flush=idex_flush=1.
  6. Load-use hazard: pc_en=ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1.
     - Hazard = ex_mem_read & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  7. Otherwise: all enables 1, no flush.
- Rules 5–7 leave MEMWAIT and return to RUN, and clear wait_cnt.
- When the state is MULDIV and mem_ready=0, the state goes to MEMWAIT and mul_cnt holds. When mem_ready returns to 1, the controller re-evaluates from rule 4; the mul/div instruction restarts its full latency.
- A flush takes effect only while the matching enable is 1. Flush without enable never occurs.
- wait_cnt saturates at MemTimeout. Reaching MemTimeout sets mem_timeout, which holds until Reset.

## Timing
- Zero-cycle decision latency: enables and flushes are valid in the same cycle as the inputs.
- Load-use costs exactly one bubble cycle.
- A taken branch costs two squashed instructions.
- A mul/div occupies EX for exactly MulDivLatency ticked cycles (entry + MulDivLatency−2 + exit).
- Reset asserted mid-MULDIV or mid-MEMWAIT returns to RUN immediately, asynchronously. After Reset: state=RUN, mul_cnt=0, wait_cnt=0, mem_timeout=0, muldiv_busy=0.
- Counter widths: mul_cnt 8 bits; wait_cnt is ceil(log2(MemTimeout+1)) bits.

## Structure
- Shared package holds the state encodings (RUN=2'd0, MULDIV=2'd1, MEMWAIT=2'd2) and a clog2 helper for counter widths.
- One sub-module: pipeline_hazard_detect, the combinational load-use comparator (id_rs/id_rt/flags vs ex_rd/ex_mem_read → hazard).
- The FSM, both counters and the output decode stay in the top module.

## Test plan
- Load r3 in EX, ID uses rs=3: one cycle with pc_en=ifid_en=0, idex_flush=1. Same case with ex_rd=0: no stall.
- Taken branch and load-use hazard in the same cycle: branch wins. All enables 1, ifid_flush=idex_flush=1.
- MulDivLatency=4, ex_muldiv_start pulse: enables 0 for 3 cycles, all 1 on the 4th, muldiv_busy high for cycles 2–4.
- mem_ready=0 for 5 cycles during RUN: enables 0 for 5 cycles, resume on the 6th. With MemTimeout=3, mem_timeout rises on the 4th wait cycle and stays high.
- Tick toggling 1,0,1 during MULDIV: mul_cnt decrements only on Tick=1 cycles, and the exit is delayed accordingly.
- Reset pulse mid-MULDIV, between edges: muldiv_busy drops immediately. Next ticked cycle with no hazards: all enables 1.
